grid_line_clear: RTL and testbench

Row-compaction engine for the Tetris playfield, directly upstream of the grid-to-video stage. After a piece locks, it scans Grid_Mem through write port A, removes every full row, shifts all rows above it down, and zero-fills the vacated top rows. Grid_To_Video keeps reading port B unchanged. The arbiter hands port A to this block while `busy` is high.

---
 rtl/grid_pkg.sv | 20 ++
 rtl/grid_row_buffer.sv | 37 +++
 rtl/grid_line_clear.sv | 198 +++++++++++++++++++
 tb/tb_grid_line_clear.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared playfield constants and the compaction FSM state type.
package grid_pkg;

  localparam int GRID_COLS = 10;
  localparam int GRID_ROWS = 20;
  localparam int CELL_W    = 8;
  localparam int ADDR_W    = 8;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/grid_row_buffer.sv
// One-row register file holding the row under evaluation, with a full-row flag.
module grid_row_buffer #(
  parameter int COLS   = 10,
  parameter int CELL_W = 8,
  parameter int IDX_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [CELL_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [CELL_W-1:0] o_rdata,
  output logic              o_row_full
);

  logic [CELL_W-1:0] r_cells [COLS];

  // Capture one cell per cycle while the row is being read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_cells[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_cells[i_ridx];

  // A row is full when no cell is empty.
  always_comb begin
    o_row_full = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      if (r_cells[i] == {CELL_W{1'b0}}) begin
        o_row_full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/grid_line_clear.sv
// Row compaction engine: removes full rows from Grid_Mem through port A,
// shifts the remaining rows down and zero-fills the vacated top rows.
//
// Handshake: start is a one-cycle request honoured only while busy is low;
// busy rises the cycle after acceptance and stays high through the done
// pulse; requests while busy is high are dropped, never queued.
module grid_line_clear
  import grid_pkg::*;
#(
  parameter int COLS   = grid_pkg::GRID_COLS,
  parameter int ROWS   = grid_pkg::GRID_ROWS,
  parameter int CELL_W = grid_pkg::CELL_W,
  parameter int ADDR_W = grid_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared,
  output logic [ADDR_W-1:0] grid_addr,
  output logic [CELL_W-1:0] grid_wdata,
  output logic              grid_we,
  input  logic [CELL_W-1:0] grid_rdata,
  output state_t            dbg_state
);

  localparam int RW    = $clog2(ROWS);
  localparam int CCW   = $clog2(COLS + 1);
  localparam int IDX_W = $clog2(COLS);

  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [CCW-1:0]    C_LAST    = CCW'(COLS - 1);
  localparam logic [CCW-1:0]    C_END     = CCW'(COLS);
  localparam logic [CCW-1:0]    C_ONE     = CCW'(1);

  state_t            r_state, w_next;
  logic [RW-1:0]     r_rd_row, r_wr_row;
  logic [ADDR_W-1:0] r_rd_base, r_wr_base;
  logic [CCW-1:0]    r_col;
  logic [4:0]        r_lines;

  logic              w_buf_we;
  logic [IDX_W-1:0]  w_buf_widx;
  logic [IDX_W-1:0]  w_buf_ridx;
  logic [CELL_W-1:0] w_buf_rdata;
  logic              w_row_full;
  logic              w_last_row;

  grid_row_buffer #(
    .COLS   (COLS),
    .CELL_W (CELL_W),
    .IDX_W  (IDX_W)
  ) u_row_buf (
    .clk        (clk),
    .i_we       (w_buf_we),
    .i_widx     (w_buf_widx),
    .i_wdata    (grid_rdata),
    .i_ridx     (w_buf_ridx),
    .o_rdata    (w_buf_rdata),
    .o_row_full (w_row_full)
  );

  // The read pointer sitting on row 0 means the scan ends after this row.
  assign w_last_row = (r_rd_row == '0);

  // Next-state and port A drive, decoded from the registered state.
  always_comb begin
    w_next     = r_state;
    grid_we    = 1'b0;
    grid_addr  = '0;
    grid_wdata = '0;
    w_buf_we   = 1'b0;
    w_buf_widx = '0;
    w_buf_ridx = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_READ;
      end
      ST_READ: begin
        if (r_col < C_END) grid_addr = r_rd_base + ADDR_W'(r_col);
        else               grid_addr = r_rd_base;
        // Read data lags the address by one cycle, so cell c lands at c+1.
        if (r_col >= C_ONE) begin
          w_buf_we   = 1'b1;
          w_buf_widx = IDX_W'(r_col - C_ONE);
        end
        if (r_col == C_END) w_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (w_row_full) begin
          w_next = w_last_row ? ST_CLEAR : ST_READ;
        end else if (r_rd_row == r_wr_row) begin
          if (w_last_row) w_next = (r_lines != '0) ? ST_CLEAR : ST_DONE;
          else            w_next = ST_READ;
        end else begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        grid_we    = 1'b1;
        grid_addr  = r_wr_base + ADDR_W'(r_col);
        w_buf_ridx = IDX_W'(r_col);
        grid_wdata = w_buf_rdata;
        if (r_col == C_LAST) begin
          if (w_last_row) w_next = (r_lines != '0) ? ST_CLEAR : ST_DONE;
          else            w_next = ST_READ;
        end
      end
      ST_CLEAR: begin
        grid_we    = 1'b1;
        grid_addr  = r_wr_base + ADDR_W'(r_col);
        grid_wdata = CELL_W'(CELL_EMPTY);
        if (r_col == C_LAST && r_wr_row == '0) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register plus row pointers, row bases, column counter and line count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rd_row  <= '0;
      r_wr_row  <= '0;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_col     <= '0;
      r_lines   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_lines   <= '0;
            r_rd_row  <= ROW_LAST;
            r_wr_row  <= ROW_LAST;
            r_rd_base <= BASE_LAST;
            r_wr_base <= BASE_LAST;
            r_col     <= '0;
          end
        end
        ST_READ: begin
          r_col <= (r_col == C_END) ? '0 : r_col + C_ONE;
        end
        ST_EVAL: begin
          if (w_row_full) begin
            r_lines   <= r_lines + 5'd1;
            r_rd_row  <= r_rd_row - 1'b1;
            r_rd_base <= r_rd_base - ROW_STEP;
          end else if (r_rd_row == r_wr_row) begin
            r_rd_row  <= r_rd_row - 1'b1;
            r_rd_base <= r_rd_base - ROW_STEP;
            r_wr_row  <= r_wr_row - 1'b1;
            r_wr_base <= r_wr_base - ROW_STEP;
          end
        end
        ST_WRITE: begin
          if (r_col == C_LAST) begin
            r_col     <= '0;
            r_rd_row  <= r_rd_row - 1'b1;
            r_rd_base <= r_rd_base - ROW_STEP;
            r_wr_row  <= r_wr_row - 1'b1;
            r_wr_base <= r_wr_base - ROW_STEP;
          end else begin
            r_col <= r_col + C_ONE;
          end
        end
        ST_CLEAR: begin
          if (r_col == C_LAST) begin
            r_col <= '0;
            if (r_wr_row != '0) begin
              r_wr_row  <= r_wr_row - 1'b1;
              r_wr_base <= r_wr_base - ROW_STEP;
            end
          end else begin
            r_col <= r_col + C_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign lines_cleared = r_lines;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: Grid_Mem model, compaction reference model,
// write scoreboard and directed playfield scenarios.
module tb_grid_line_clear;
  import grid_pkg::*;

  localparam int C = 10;
  localparam int R = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, grid_we;
  logic [4:0] lines_cleared;
  logic [7:0] grid_addr, grid_wdata, grid_rdata;
  state_t dbg_state;

  always #5 clk = ~clk;

  grid_line_clear dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .grid_addr     (grid_addr),
    .grid_wdata    (grid_wdata),
    .grid_we       (grid_we),
    .grid_rdata    (grid_rdata),
    .dbg_state     (dbg_state)
  );

  // ---------------- Grid_Mem port A model ----------------
  logic [7:0] mem [R*C];
  logic       tb_load;
  logic [7:0] tb_addr, tb_wdata;

  always @(posedge clk) begin
    if (tb_load) mem[tb_addr] <= tb_wdata;
    else if (grid_we && grid_addr < 8'(R*C)) mem[grid_addr] <= grid_wdata;
    grid_rdata <= (grid_addr < 8'(R*C)) ? mem[grid_addr] : 8'h00;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  bit  mon_en   = 1'b0;
  int  done_cnt = 0;

  logic [7:0] g     [R][C];
  logic [7:0] exp_g [R][C];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Every port A write must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (grid_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0h, expected no write", grid_addr, grid_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          check("write_addr_data", {16'h0, grid_addr, grid_wdata}, {16'h0, exp_w});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Keep non-full rows in bottom-up order, stack them at the bottom, zero the rest.
  task automatic model(output int lines, output int moved);
    int  dst;
    bit  full;
    dst = R - 1;
    lines = 0;
    moved = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_g[r][c] = 8'h00;
    for (int r = R - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < C; c++) if (g[r][c] == 8'h00) full = 1'b0;
      if (full) begin
        lines++;
      end else begin
        for (int c = 0; c < C; c++) exp_g[dst][c] = g[r][c];
        if (dst != r) begin
          moved++;
          for (int c = 0; c < C; c++) exp_q.push_back({8'(dst*C + c), g[r][c]});
        end
        dst--;
      end
    end
    for (int r = lines - 1; r >= 0; r--)
      for (int c = 0; c < C; c++) exp_q.push_back({8'(r*C + c), 8'h00});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_grid(input int kind);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        case (kind)
          0: g[r][c] = 8'h00;
          1: g[r][c] = (r == R-1) ? 8'h03 : ((c == 0) ? 8'h05 : 8'h00);
          2: g[r][c] = (r == 17 || r == 19) ? 8'h02 : ((r == 18 && c == 0) ? 8'h07 : 8'h00);
          3: g[r][c] = 8'h01;
          4: g[r][c] = (r == 0) ? 8'h09 : ((r == R-1 && c == 1) ? 8'h04 : 8'h00);
          default: g[r][c] = 8'h00;
        endcase
      end
  endtask

  task automatic load_grid();
    for (int i = 0; i < R*C; i++) begin
      @(negedge clk);
      tb_load  = 1'b1;
      tb_addr  = 8'(i);
      tb_wdata = g[i / C][i % C];
    end
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  task automatic run(input int lit_lat, input int lit_lines, input bit extra_start);
    int  lines, moved, lat_m, k, bad;
    bit  got;
    exp_q.delete();
    model(lines, moved);
    lat_m = 1 + R*(C+2) + moved*C + lines*C;
    check("model_latency", lat_m, lit_lat);
    check("model_lines", lines, lit_lines);
    load_grid();
    done_cnt = 0;
    mon_en   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 1);
    got = 1'b0;
    for (k = 1; k < 3000; k++) begin
      start = (extra_start && k == 3);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", k, lat_m);
    end
    check("latency", k, lat_m);
    check("lines_cleared", {27'h0, lines_cleared}, lines);
    check("busy_at_done", {31'h0, busy}, 1);
    repeat (3) @(negedge clk);
    check("busy_after_done", {31'h0, busy}, 0);
    check("done_pulses", done_cnt, 1);
    check("writes_outstanding", exp_q.size(), 0);
    mon_en = 1'b0;
    bad = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) if (mem[r*C + c] !== exp_g[r][c]) bad++;
    check("grid_cells_wrong", bad, 0);
  endtask

  task automatic reset_in_write();
    int k;
    set_grid(1);
    load_grid();
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!grid_we && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reached_write", {31'h0, grid_we}, 1);
    check("state_write", {29'h0, dbg_state}, {29'h0, ST_WRITE});
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_lines", {27'h0, lines_cleared}, 0);
    check("rst_we", {31'h0, grid_we}, 0);
    check("rst_addr", {24'h0, grid_addr}, 0);
    check("rst_wdata", {24'h0, grid_wdata}, 0);
    check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    tb_load = 1'b0;
    tb_addr = 8'h00;
    tb_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_done", {31'h0, done}, 0);
    check("reset_lines", {27'h0, lines_cleared}, 0);
    check("reset_we", {31'h0, grid_we}, 0);
    check("reset_addr", {24'h0, grid_addr}, 0);
    check("reset_wdata", {24'h0, grid_wdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty grid: pure scan, no writes.
    set_grid(0);
    run(241, 0, 1'b0);

    // Bottom row full, everything above shifts down one row.
    set_grid(1);
    run(441, 1, 1'b0);
    check("c1_row19_col0", {24'h0, mem[190]}, 32'h05);
    check("c1_row19_col1", {24'h0, mem[191]}, 32'h00);
    check("c1_row0_col0", {24'h0, mem[0]}, 32'h00);
    check("c1_row1_col0", {24'h0, mem[10]}, 32'h05);

    // Rows 17 and 19 full with a partial row between them.
    set_grid(2);
    run(441, 2, 1'b0);
    check("c2_row19_col0", {24'h0, mem[190]}, 32'h07);
    check("c2_row18_col0", {24'h0, mem[180]}, 32'h00);
    check("c2_row0_col0", {24'h0, mem[0]}, 32'h00);

    // Whole playfield full.
    set_grid(3);
    run(441, 20, 1'b0);
    check("c3_last_cell", {24'h0, mem[199]}, 32'h00);

    // Top row full only: the final row evaluated is the one removed.
    set_grid(4);
    run(251, 1, 1'b0);
    check("c4_row19_col1", {24'h0, mem[191]}, 32'h04);

    // Second start during READ is dropped.
    set_grid(1);
    run(441, 1, 1'b1);

    // Reset in WRITE, then a clean run on a freshly loaded grid.
    reset_in_write();
    @(negedge clk);
    set_grid(2);
    run(441, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
